// File: rtl/alu_mdu.sv
// Integer ALU with combinational ops plus a radix-2 multi-cycle multiply/divide
// unit that owns the architectural HI/LO registers (start/busy/done handshake).
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int OP_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    aluControl,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  input  logic               start,
  output logic [WIDTH-1:0]   aluOut,
  output logic               equal,
  output logic               overflow,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [OP_W-1:0] OP_NONE  = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'('h01);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'('h03);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'('h05);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'('h06);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'('h07);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'('h08);
  localparam logic [OP_W-1:0] OP_SLLV  = OP_W'('h09);
  localparam logic [OP_W-1:0] OP_SRLV  = OP_W'('h0A);
  localparam logic [OP_W-1:0] OP_SRAV  = OP_W'('h0B);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'('h0C);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'('h0D);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'('h10);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'('h11);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'('h12);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'('h13);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'('h14);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'('h15);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT state, nextState;

  // ---------------- combinational ALU ----------------
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   addSum, subDiff;

  assign shamt   = srcA[SHAMT_W-1:0];
  assign addSum  = srcA + srcB;
  assign subDiff = srcA - srcB;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    aluOut   = '0;
    overflow = 1'b0;
    case (aluControl)
      OP_NONE: aluOut = srcB;
      OP_ADD: begin
        aluOut   = addSum;
        overflow = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (addSum[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_SUB: begin
        aluOut   = subDiff;
        overflow = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (subDiff[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_AND:  aluOut = srcA & srcB;
      OP_OR:   aluOut = srcA | srcB;
      OP_XOR:  aluOut = srcA ^ srcB;
      OP_NOR:  aluOut = ~(srcA | srcB);
      OP_SLT:  aluOut = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      OP_SLTU: aluOut = {{(WIDTH-1){1'b0}}, srcA < srcB};
      OP_SLLV: aluOut = srcB << shamt;
      OP_SRLV: aluOut = srcB >> shamt;
      OP_SRAV: aluOut = $signed(srcB) >>> shamt;
      OP_MFHI: aluOut = hi;
      OP_MFLO: aluOut = lo;
      default: aluOut = '0;
    endcase
  end

  assign equal = (aluOut == '0);

  // ---------------- multiply/divide unit ----------------
  logic             startAcc, mduLaunch, opSigned, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;

  assign startAcc  = start && (state == IDLE) && (aluControl inside {[OP_MULT:OP_MTLO]});
  assign mduLaunch = startAcc && (aluControl inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign opSigned  = (aluControl == OP_MULT) || (aluControl == OP_DIV);
  assign aNeg      = opSigned && srcA[WIDTH-1];
  assign bNeg      = opSigned && srcB[WIDTH-1];
  assign aMag      = aNeg ? -srcA : srcA;
  assign bMag      = bNeg ? -srcB : srcB;

  // Working registers: acc is the upper product half / partial remainder,
  // qReg shifts the multiplier out and the quotient in.
  logic [WIDTH-1:0] acc, qReg, opnd;
  logic [CNT_W-1:0] count;
  logic             isDiv, negResult, negRem, divZero;

  logic [WIDTH:0]     mulSum;
  logic               divGeq;
  logic [WIDTH-1:0]   divDiff;

  assign mulSum  = {1'b0, acc} + (qReg[0] ? {1'b0, opnd} : '0);
  assign divGeq  = {acc, qReg[WIDTH-1]} >= {1'b0, opnd};
  // The trial remainder is below 2*divisor, so the low WIDTH bits are exact when divGeq.
  assign divDiff = {acc[WIDTH-2:0], qReg[WIDTH-1]} - opnd;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (mduLaunch) nextState = RUN;
      RUN:     if (count == CNT_W'(1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // NOTE: the iteration datapath has no reset; the FSM never consumes it before a launch loads it.
  always_ff @(posedge clk) begin
    if (mduLaunch) begin
      acc       <= '0;
      qReg      <= aMag;
      opnd      <= bMag;
      count     <= CNT_W'(WIDTH);
      isDiv     <= (aluControl == OP_DIV) || (aluControl == OP_DIVU);
      negResult <= aNeg ^ bNeg;
      negRem    <= aNeg;
      divZero   <= (srcB == '0);
    end else if (state == RUN) begin
      count <= count - 1'b1;
      if (isDiv) begin
        acc  <= divGeq ? divDiff : {acc[WIDTH-2:0], qReg[WIDTH-1]};
        qReg <= {qReg[WIDTH-2:0], divGeq};
      end else begin
        acc  <= mulSum[WIDTH:1];
        qReg <= {mulSum[0], qReg[WIDTH-1:1]};
      end
    end
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prodMag, fixProd;
  logic [WIDTH-1:0]   fixQuot, fixRem;

  assign prodMag = {acc, qReg};
  assign fixProd = negResult ? -prodMag : prodMag;
  assign fixQuot = divZero ? '1 : (negResult ? -qReg : qReg);
  assign fixRem  = negRem ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        if (isDiv) begin
          hi <= fixRem;
          lo <= fixQuot;
        end else begin
          hi <= fixProd[2*WIDTH-1:WIDTH];
          lo <= fixProd[WIDTH-1:0];
        end
      end else if (startAcc && aluControl == OP_MTHI) begin
        hi <= srcA;
      end else if (startAcc && aluControl == OP_MTLO) begin
        lo <= srcA;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: arithmetic reference model, scoreboard queue
// filled at issue time and drained by a monitor watching done.
module tb_alu_mdu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    aluControl;
  logic [W-1:0]  srcA, srcB;
  logic          start;
  logic [W-1:0]  aluOut, hi, lo;
  logic          equal, overflow, busy, done;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   sbQ[$];
  logic [63:0]   lastExp = '0;
  logic [W-1:0]  mHi = '0;
  logic [W-1:0]  mLo = '0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W), .SHAMT_W(5), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .aluControl(aluControl), .srcA(srcA), .srcB(srcB),
    .start(start), .aluOut(aluOut), .equal(equal), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model for the combinational ops
  function automatic void aluModel(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic ovf);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint exact;
    r = '0;
    ovf = 1'b0;
    case (op)
      5'h00: r = b;
      5'h01: begin exact = sa + sb; r = a + b; ovf = (exact != longint'($signed(r))); end
      5'h02: begin exact = sa - sb; r = a - b; ovf = (exact != longint'($signed(r))); end
      5'h03: r = a & b;
      5'h04: r = a | b;
      5'h05: r = a ^ b;
      5'h06: r = ~(a | b);
      5'h07: r = (sa < sb) ? 1 : 0;
      5'h08: r = (a < b) ? 1 : 0;
      5'h09: r = b << a[4:0];
      5'h0A: r = b >> a[4:0];
      5'h0B: r = $signed(b) >>> a[4:0];
      5'h0C: r = mHi;
      5'h0D: r = mLo;
      default: r = '0;
    endcase
  endfunction

  // Reference model for MULT/MULTU/DIV/DIVU: returns {hi, lo}
  function automatic logic [63:0] mduModel(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [63:0] pu;
    int sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      5'h10: begin p = longint'(sa) * longint'(sb); return p; end
      5'h11: begin pu = {32'b0, a} * {32'b0, b}; return pu; end
      5'h12: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic combCheck(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic ovf;
    aluControl = op;
    srcA = a;
    srcB = b;
    start = 1'b0;
    #1;
    aluModel(op, a, b, r, ovf);
    check($sformatf("alu_op%02h_out", op), aluOut, r);
    check($sformatf("alu_op%02h_equal", op), equal, (r == 0));
    check($sformatf("alu_op%02h_ovf", op), overflow, ovf);
  endtask

  task automatic mduIssue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    aluControl = op;
    srcA = a;
    srcB = b;
    start = 1'b1;
    if (op <= 5'h13) begin
      lastExp = mduModel(op, a, b);
      sbQ.push_back(lastExp);
    end
    step();
    start = 1'b0;
    if (op == 5'h14) begin
      mHi = a;
      check("mthi_hi", hi, a);
      check("mthi_no_done", done, 0);
    end else if (op == 5'h15) begin
      mLo = a;
      check("mtlo_lo", lo, a);
      check("mtlo_no_done", done, 0);
    end else begin
      check("busy_after_start", busy, 1);
    end
  endtask

  // Returns in the done cycle so the next op can be launched back-to-back.
  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("done_seen", done, 1);
    mHi = lastExp[63:32];
    mLo = lastExp[31:0];
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done pulse and checks busy length
  initial begin
    logic [63:0] e;
    int busyLen = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbQ.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sbQ.pop_front();
          check("mdu_hi", hi, e[63:32]);
          check("mdu_lo", lo, e[31:0]);
          check("busy_cycles", busyLen, W + 1);
        end
      end
      if (busy === 1'b1) begin
        check("hilo_stable", {hi, lo}, {mHi, mLo});
        busyLen++;
      end else begin
        busyLen = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    rst = 1'b1;
    aluControl = 5'h01;
    srcA = '0;
    srcB = '0;
    start = 1'b0;
    step();
    rst = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aluOut", aluOut, 0);
    check("rst_equal", equal, 1);

    // Directed combinational cases
    combCheck(5'h01, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_value", {aluOut, 31'b0, overflow}, {32'h8000_0000, 32'h1});
    combCheck(5'h02, 32'h8000_0000, 32'h1);
    combCheck(5'h0B, 32'h4, 32'h8000_0000);
    check("srav_value", aluOut, 32'hF800_0000);
    combCheck(5'h07, 32'hFFFF_FFFF, 32'h1);
    check("slt_value", aluOut, 1);
    combCheck(5'h08, 32'hFFFF_FFFF, 32'h1);
    check("sltu_value", aluOut, 0);
    combCheck(5'h1F, 32'h1234, 32'h5678);

    // Directed multiply/divide
    mduIssue(5'h10, -32'sd3, 32'd5);
    waitDone();
    check("mult_value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    mduIssue(5'h11, 32'hFFFF_FFFF, 32'd2);
    waitDone();
    check("multu_value", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    mduIssue(5'h12, -32'sd7, 32'd2);
    waitDone();
    check("div_value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    mduIssue(5'h13, 32'd100, 32'd7);
    waitDone();
    check("divu_value", {hi, lo}, {32'd2, 32'd14});
    mduIssue(5'h13, 32'd5, 32'd0);
    waitDone();
    check("divu_zero_value", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    mduIssue(5'h12, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone();
    mduIssue(5'h12, -32'sd7, 32'd0);
    waitDone();

    // start while busy is ignored; MFLO during busy returns the old value
    mduIssue(5'h10, 32'h0123_4567, 32'hFFFF_89AB);
    repeat (3) step();
    aluControl = 5'h13;
    srcA = 32'd1000;
    srcB = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    combCheck(5'h0D, 32'h0, 32'h0);
    srcA = 32'hDEAD_BEEF;
    srcB = 32'h0BAD_F00D;
    waitDone();

    // HI/LO moves
    mduIssue(5'h15, 32'h1234, 32'h0);
    combCheck(5'h0D, 32'h0, 32'h0);
    check("mflo_value", aluOut, 32'h1234);
    mduIssue(5'h14, 32'hCAFE_0001, 32'h0);
    combCheck(5'h0C, 32'h0, 32'h0);
    repeat (3) step();

    // Reset in the middle of a divide, then a clean multiply
    mduIssue(5'h12, 32'd123456, 32'd789);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sbQ.delete();
    mHi = '0;
    mLo = '0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hilo", {hi, lo}, 64'h0);
    repeat (40) step();
    check("abort_hilo_later", {hi, lo}, 64'h0);
    mduIssue(5'h10, 32'd40000, -32'sd70000);
    waitDone();

    // Randomized combinational ops
    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 31));
      combCheck(op, randOperand(), randOperand());
    end

    // Randomized MDU ops, launched back-to-back in the done cycle
    for (int i = 0; i < 30; i++) begin
      op = 5'(16 + $urandom_range(0, 5));
      mduIssue(op, randOperand(), randOperand());
      if (op <= 5'h13) begin
        waitDone();
        combCheck(5'h0C, 32'h0, 32'h0);
        combCheck(5'h0D, 32'h0, 32'h0);
      end
    end

    repeat (4) step();
    check("scoreboard_empty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle ALU.
- Combinational integer ops with the same srcA/srcB/aluOut/equal convention, plus a multi-cycle multiply/divide unit.
- The multiply/divide unit owns architectural HI/LO registers and uses a start/busy/done handshake.
- Sits in EX of the single-cycle and pipelined cores. The control unit stalls the PC while busy is high.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two and at least 8.
- SHAMT_W, 5, shift-amount bits taken from srcA; equals log2(WIDTH).
- OP_W, 5, width of the aluControl field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- aluControl  in  OP_W  operation select; encoding under Behaviour.
- srcA  in  WIDTH  operand A; shift amount is srcA[SHAMT_W-1:0].
- srcB  in  WIDTH  operand B; the shifted value for shifts.
- start  in  1  launches the multi-cycle op or HI/LO write currently on aluControl.
- aluOut  out  WIDTH  combinational result.
- equal  out  1  high when aluOut is all zeros.
- overflow  out  1  signed overflow on ADD/SUB; 0 for all other ops.
- busy  out  1  multiply/divide in progress.
- done  out  1  one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset is synchronous active-high and wins over everything. At an edge with rst=1: hi=0, lo=0, busy=0, done=0, FSM to IDLE. An in-flight op is aborted with no HI/LO write.
- Combinational ops, aluOut valid in the same cycle (codes in hex):
  - 00 NONE: aluOut=srcB.
  - 01 ADD: srcA+srcB, modulo 2^WIDTH.
  - 02 SUB: srcA-srcB, modulo 2^WIDTH.
  - 03 AND, 04 OR, 05 XOR, 06 NOR.
  - 07 SLT: signed compare, zero-extended 1/0.
  - 08 SLTU: unsigned compare, zero-extended 1/0.
  - 09 SLLV: srcB<<sh; 0A SRLV: srcB>>sh (logical); 0B SRAV: srcB>>>sh (arithmetic).
  - 0C MFHI: aluOut=hi; 0D MFLO: aluOut=lo.
  - Any other code: aluOut=0.
- Multi-cycle and HI/LO-write ops: 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MTHI, 15 MTLO. aluOut=0 for all of these.
- overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from srcA.
  - The result is still produced; overflow does not trap.
- start is accepted only when busy=0 and aluControl is in 10..15. It is ignored otherwise, including while busy; operands are not re-sampled.
- MTHI / MTLO: hi (or lo) = srcA at the accepting edge. No busy, no done.
- MULT/MULTU/DIV/DIVU FSM, IDLE -> RUN -> FIX -> IDLE:
  - Accepting edge: latch operands. For signed ops, store magnitudes and sign flags. Counter=WIDTH, busy=1.
  - RUN: one radix-2 iteration per cycle. Multiply is shift-add; divide is restoring, one quotient bit per cycle. Exactly WIDTH cycles, then go to FIX.
  - FIX: one cycle. Apply two's-complement sign correction. At the end of FIX: hi/lo written, busy=0, done=1, return to IDLE.
  - done falls to 0 on the next edge.
  - busy is high for exactly WIDTH+1 cycles after the accepting edge.
  - A new start may be accepted in the cycle where done=1.
- Multiply results: {hi,lo} is the full 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
- Divide results: lo=quotient, hi=remainder. The quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: hi=srcA (dividend), lo=all ones. Same latency; no exception.
- Signed DIV of most-negative by -1: lo=most-negative value, hi=0. No exception.
- hi/lo are stable while busy. MFHI/MFLO during busy return the old values; stalling them is the controller's job.

Test Plan:
- Reset: pulse rst=1 for 1 cycle -> hi=0, lo=0, busy=0, done=0. With aluControl=01, srcA=0, srcB=0: aluOut=0 and equal=1.
- Combinational, WIDTH=32:
  - ADD 0x7FFFFFFF+1 -> aluOut=0x80000000, overflow=1.
  - SRAV srcB=0x80000000, srcA=4 -> 0xF8000000.
  - SLT -1,1 -> 1; SLTU -1,1 -> 0.
- MULT srcA=-3, srcB=5 with a start pulse:
  - busy high for 33 cycles.
  - done pulses with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- Divide:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 -> lo=14, hi=2.
  - DIVU 5/0 -> hi=5, lo=0xFFFFFFFF after 33 busy cycles.
- Handshake:
  - start with DIVU while busy from MULT -> ignored; MULT result unchanged.
  - MTLO srcA=0x1234 -> lo=0x1234 next cycle, no done pulse.
  - MFLO -> aluOut=0x1234.
- Reset at cycle 10 of a DIV -> busy=0, hi=lo=0, no done pulse. A following MULT completes correctly.
